// File: rtl/ifu_mem_pkg.sv
// Shared fetch-side definitions: reset PC, the NOP used for faulted fetches,
// responder FSM states and the address legality check.
package ifu_mem_pkg;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // True when addr is misaligned or outside [base, base+span). The offset is
  // compared in 33 bits so a window touching the top of memory never wraps.
  function automatic logic addr_bad(input logic [31:0] addr,
                                    input logic [31:0] base,
                                    input logic [32:0] span);
    logic [31:0] off;
    off = addr - base;
    return (addr[1:0] != 2'b00) || (addr < base) || ({1'b0, off} >= span);
  endfunction

endpackage

// File: rtl/inst_mem_responder_if.sv
// Fetch request/response channel plus the debug preload port.
interface inst_mem_responder_if;

  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_inst;
  logic        rsp_err;
  logic        dbg_we;
  logic [31:0] dbg_addr;
  logic [31:0] dbg_wdata;

  // Fetch unit / bench side
  modport master (
    output req_valid, req_addr, rsp_ready, dbg_we, dbg_addr, dbg_wdata,
    input  req_ready, rsp_valid, rsp_inst, rsp_err
  );

  // Responder side
  modport slave (
    input  req_valid, req_addr, rsp_ready, dbg_we, dbg_addr, dbg_wdata,
    output req_ready, rsp_valid, rsp_inst, rsp_err
  );

endinterface

// File: rtl/inst_ram.sv
// DEPTH x 32 instruction array: one synchronous write port, one synchronous
// read port; a read colliding with a write to the same word returns old data.
module inst_ram #(
  parameter int DEPTH = 4096,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];
  logic [31:0] rdata_q;

  // Write and read on the same edge; non-blocking update gives read-old-data
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/inst_mem_responder.sv
// Instruction-memory responder: accepts one fetch at a time, waits a fixed
// latency, then presents the array word (or a NOP with error) until consumed.
module inst_mem_responder
  import ifu_mem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = RESET_PC,
  parameter int          DEPTH     = 4096,
  parameter int          LATENCY   = 2
) (
  input logic                 clk,
  input logic                 reset,
  inst_mem_responder_if.slave bus
);

  localparam int          IDX_W    = $clog2(DEPTH);
  localparam logic [32:0] SPAN     = 33'(DEPTH) << 2;
  localparam logic [3:0]  CNT_LOAD = 4'(LATENCY - 1);

  // Word index of a byte address; only meaningful once the range check passed
  function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] a);
    return IDX_W'((a - BASE_ADDR) >> 2);
  endfunction

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             err_q, err_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  logic             req_err;
  logic [IDX_W-1:0] req_idx;
  logic             rd_en;
  logic [IDX_W-1:0] rd_idx;
  logic             wr_en;
  logic [IDX_W-1:0] wr_idx;
  logic [31:0]      ram_rdata;

  assign req_err = addr_bad(bus.req_addr, BASE_ADDR, SPAN);
  assign req_idx = word_idx(bus.req_addr);

  // With LATENCY=1 the read is issued straight from the incoming address
  assign rd_idx  = (state_q == IDLE) ? req_idx : idx_q;

  // Illegal debug addresses are dropped so they cannot alias onto a real word
  assign wr_en   = bus.dbg_we && !addr_bad(bus.dbg_addr, BASE_ADDR, SPAN);
  assign wr_idx  = word_idx(bus.dbg_addr);

  // Next-state, latency countdown and read issue on the edge entering RESP
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    idx_d   = idx_q;
    rd_en   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          idx_d = req_idx;
          err_d = req_err;
          cnt_d = CNT_LOAD;
          if (LATENCY == 1) begin
            state_d = RESP;
            rd_en   = !req_err;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
          rd_en   = !err_q;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state; reset discards any in-flight request
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Latched word index of the pending fetch
  always_ff @(posedge clk) begin
    idx_q <= idx_d;
  end

  inst_ram #(
    .DEPTH (DEPTH),
    .AW    (IDX_W)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_idx),
    .wdata (bus.dbg_wdata),
    .re    (rd_en),
    .raddr (rd_idx),
    .rdata (ram_rdata)
  );

  // The RAM output register holds the word through any backpressure
  assign bus.req_ready = (state_q == IDLE) && reset;
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_err   = (state_q == RESP) && err_q;
  assign bus.rsp_inst  = (state_q != RESP) ? 32'h0 :
                         (err_q ? NOP_INST : ram_rdata);

endmodule

// File: tb/tb_inst_mem_responder.sv
// Bench for inst_mem_responder: a LATENCY=2 instance and a LATENCY=1 instance
// sharing clock and reset; responses are checked against a queue of expected
// words filled when each request is accepted.
module tb_inst_mem_responder;
  import ifu_mem_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  inst_mem_responder_if ifa();
  inst_mem_responder_if ifb();

  inst_mem_responder #(.BASE_ADDR(32'h8000_0000), .DEPTH(4096), .LATENCY(2)) dut_a (
    .clk(clk), .reset(reset), .bus(ifa));
  inst_mem_responder #(.BASE_ADDR(32'h8000_0000), .DEPTH(4096), .LATENCY(1)) dut_b (
    .clk(clk), .reset(reset), .bus(ifb));

  typedef struct packed { logic [31:0] inst; logic err; } rsp_t;
  typedef struct { string nm; logic [31:0] addr; logic [31:0] inst; logic err; } vec_t;

  rsp_t qa[$];
  rsp_t qb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  vec_t tbl[9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Scoreboard for instance A: every consumed response must match the queue
  always begin : mon_a
    rsp_t e;
    @(negedge clk);
    #3;
    if (reset && ifa.rsp_valid && ifa.rsp_ready) begin
      chk("a_pending", 32'(qa.size() > 0), 32'd1);
      if (qa.size() > 0) begin
        e = qa.pop_front();
        chk("a_inst", ifa.rsp_inst, e.inst);
        chk("a_err", 32'(ifa.rsp_err), 32'(e.err));
      end
    end
  end

  // Scoreboard for instance B
  always begin : mon_b
    rsp_t e;
    @(negedge clk);
    #3;
    if (reset && ifb.rsp_valid && ifb.rsp_ready) begin
      chk("b_pending", 32'(qb.size() > 0), 32'd1);
      if (qb.size() > 0) begin
        e = qb.pop_front();
        chk("b_inst", ifb.rsp_inst, e.inst);
        chk("b_err", 32'(ifb.rsp_err), 32'(e.err));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  task automatic dbg_wr(input bit to_b, input logic [31:0] a, input logic [31:0] d);
    if (to_b) begin
      ifb.dbg_we = 1'b1; ifb.dbg_addr = a; ifb.dbg_wdata = d;
    end else begin
      ifa.dbg_we = 1'b1; ifa.dbg_addr = a; ifa.dbg_wdata = d;
    end
    step();
    ifa.dbg_we = 1'b0;
    ifb.dbg_we = 1'b0;
  endtask

  // One fetch on instance A; optionally a debug write asserted wr_at cycles
  // after the accept edge (0 -> lands on accept+1, 1 -> on the RESP-entry edge)
  task automatic fetch_a(input string nm, input logic [31:0] addr, input logic [31:0] ei,
                         input logic ee, input int wr_at, input logic [31:0] wa,
                         input logic [31:0] wd);
    int n;
    ifa.req_valid = 1'b1;
    ifa.req_addr  = addr;
    ifa.rsp_ready = 1'b1;
    n = 0;
    while (!ifa.req_ready && n < 20) begin step(); n++; end
    chk({nm, "_ready"}, 32'(ifa.req_ready), 32'd1);
    if (!ifa.req_ready) begin
      ifa.req_valid = 1'b0;
      return;
    end
    qa.push_back(rsp_t'{ei, ee});
    step();
    ifa.req_addr = ~addr;
    n = 0;
    while (!ifa.rsp_valid && n < 20) begin
      ifa.dbg_we    = (n == wr_at);
      ifa.dbg_addr  = wa;
      ifa.dbg_wdata = wd;
      step();
      n++;
    end
    ifa.dbg_we    = 1'b0;
    ifa.req_valid = 1'b0;
    chk({nm, "_lat"}, 32'(n), 32'd2);
    step();
    chk({nm, "_idle"}, 32'({ifa.req_ready, ifa.rsp_valid}), 32'b10);
  endtask

  initial begin
    int n;
    tbl[0] = '{"w0",    32'h8000_0000, 32'h0000_0297, 1'b0};
    tbl[1] = '{"w1",    32'h8000_0004, 32'h0010_0093, 1'b0};
    tbl[2] = '{"top",   32'h8000_3FFC, 32'hCAFE_F00D, 1'b0};
    tbl[3] = '{"mis2",  32'h8000_0002, NOP_INST,      1'b1};
    tbl[4] = '{"past",  32'h8000_4000, NOP_INST,      1'b1};
    tbl[5] = '{"below", 32'h7FFF_FFFC, NOP_INST,      1'b1};
    tbl[6] = '{"hi",    32'hFFFF_FFFC, NOP_INST,      1'b1};
    tbl[7] = '{"w5",    32'h8000_0014, 32'h1234_5678, 1'b0};
    tbl[8] = '{"mis1",  32'h8000_0001, NOP_INST,      1'b1};

    reset = 1'b0;
    ifa.req_valid = 1'b1; ifa.req_addr = 32'h8000_0000; ifa.rsp_ready = 1'b0;
    ifa.dbg_we = 1'b0; ifa.dbg_addr = '0; ifa.dbg_wdata = '0;
    ifb.req_valid = 1'b0; ifb.req_addr = '0; ifb.rsp_ready = 1'b0;
    ifb.dbg_we = 1'b0; ifb.dbg_addr = '0; ifb.dbg_wdata = '0;
    repeat (3) step();

    chk("rst_a_ready", 32'(ifa.req_ready), 32'd0);
    chk("rst_a_valid", 32'(ifa.rsp_valid), 32'd0);
    chk("rst_a_inst",  ifa.rsp_inst, 32'h0);
    chk("rst_a_err",   32'(ifa.rsp_err), 32'd0);
    chk("rst_b_ready", 32'(ifb.req_ready), 32'd0);
    chk("rst_b_valid", 32'(ifb.rsp_valid), 32'd0);
    ifa.req_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("rel_a_ready", 32'(ifa.req_ready), 32'd1);
    chk("rel_b_ready", 32'(ifb.req_ready), 32'd1);

    // Preload; the three illegal writes would alias onto words 1, 0 and 4095
    dbg_wr(1'b0, 32'h8000_0000, 32'h0000_0297);
    dbg_wr(1'b0, 32'h8000_0004, 32'h0010_0093);
    dbg_wr(1'b0, 32'h8000_3FFC, 32'hCAFE_F00D);
    dbg_wr(1'b0, 32'h8000_0014, 32'h1234_5678);
    dbg_wr(1'b0, 32'h8000_001C, 32'h1111_1111);
    dbg_wr(1'b0, 32'h8000_0020, 32'h2222_2222);
    dbg_wr(1'b0, 32'h8000_0006, 32'hBAD0_BAD0);
    dbg_wr(1'b0, 32'h8000_4000, 32'hBAD1_BAD1);
    dbg_wr(1'b0, 32'h7FFF_FFFC, 32'hBAD2_BAD2);
    dbg_wr(1'b1, 32'h8000_0000, 32'h0000_0297);
    dbg_wr(1'b1, 32'h8000_0004, 32'h0040_8093);

    foreach (tbl[i]) fetch_a(tbl[i].nm, tbl[i].addr, tbl[i].inst, tbl[i].err, -1, '0, '0);

    // Backpressure: response held 5 cycles while new requests are ignored
    ifa.req_valid = 1'b1; ifa.req_addr = 32'h8000_0014; ifa.rsp_ready = 1'b0;
    chk("bp_accept", 32'(ifa.req_ready), 32'd1);
    qa.push_back(rsp_t'{32'h1234_5678, 1'b0});
    step();
    ifa.req_addr = 32'h8000_0000;
    n = 0;
    while (!ifa.rsp_valid && n < 20) begin step(); n++; end
    chk("bp_lat", 32'(n), 32'd2);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 32'(ifa.rsp_valid), 32'd1);
      chk("bp_inst",  ifa.rsp_inst, 32'h1234_5678);
      chk("bp_err",   32'(ifa.rsp_err), 32'd0);
      chk("bp_ready", 32'(ifa.req_ready), 32'd0);
      ifa.req_addr = ifa.req_addr + 32'd4;
      step();
    end
    ifa.req_valid = 1'b0;
    ifa.rsp_ready = 1'b1;
    step();
    chk("bp_release", 32'({ifa.req_ready, ifa.rsp_valid}), 32'b10);

    // Debug write on the RESP-entry edge returns old data; one edge earlier is seen
    fetch_a("coll",  32'h8000_001C, 32'h1111_1111, 1'b0, 1,  32'h8000_001C, 32'hDEAD_BEEF);
    fetch_a("coll2", 32'h8000_001C, 32'hDEAD_BEEF, 1'b0, -1, '0, '0);
    fetch_a("early", 32'h8000_0020, 32'hDEAD_BEEF, 1'b0, 0,  32'h8000_0020, 32'hDEAD_BEEF);

    // Reset while a response is being presented: valid drops without a clock
    ifa.req_valid = 1'b1; ifa.req_addr = 32'h8000_0004; ifa.rsp_ready = 1'b0;
    step();
    ifa.req_valid = 1'b0;
    n = 0;
    while (!ifa.rsp_valid && n < 20) begin step(); n++; end
    chk("rr_valid_before", 32'(ifa.rsp_valid), 32'd1);
    reset = 1'b0;
    #1;
    chk("rr_valid_async", 32'(ifa.rsp_valid), 32'd0);
    chk("rr_inst", ifa.rsp_inst, 32'h0);
    qa.delete();
    step();
    reset = 1'b1;
    ifa.rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rr_quiet", 32'({ifa.req_ready, ifa.rsp_valid}), 32'b10);
    end

    // Reset while waiting: request discarded, no stray response afterwards
    ifa.req_valid = 1'b1; ifa.req_addr = 32'h8000_0000;
    step();
    ifa.req_valid = 1'b0;
    chk("rw_in_wait", 32'({ifa.req_ready, ifa.rsp_valid}), 32'b00);
    reset = 1'b0;
    #1;
    chk("rw_valid", 32'(ifa.rsp_valid), 32'd0);
    chk("rw_ready", 32'(ifa.req_ready), 32'd0);
    qa.delete();
    step();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rw_quiet", 32'({ifa.req_ready, ifa.rsp_valid}), 32'b10);
    end
    fetch_a("after_rst", 32'h8000_0000, 32'h0000_0297, 1'b0, -1, '0, '0);

    // LATENCY=1 back-to-back: each response one cycle after accept, accepts 2 apart
    ifb.rsp_ready = 1'b1;
    ifb.req_valid = 1'b1; ifb.req_addr = 32'h8000_0000;
    chk("b2b_rdy0", 32'(ifb.req_ready), 32'd1);
    qb.push_back(rsp_t'{32'h0000_0297, 1'b0});
    step();
    chk("b2b_rsp0", 32'({ifb.rsp_valid, ifb.req_ready}), 32'b10);
    ifb.req_addr = 32'h8000_0004;
    step();
    chk("b2b_rdy1", 32'({ifb.rsp_valid, ifb.req_ready}), 32'b01);
    qb.push_back(rsp_t'{32'h0040_8093, 1'b0});
    step();
    chk("b2b_rsp1", 32'({ifb.rsp_valid, ifb.req_ready}), 32'b10);
    ifb.req_valid = 1'b0;
    step();
    chk("b2b_done", 32'({ifb.rsp_valid, ifb.req_ready}), 32'b01);

    repeat (3) step();
    chk("a_queue_empty", 32'(qa.size()), 32'd0);
    chk("b_queue_empty", 32'(qb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
